regfile: RTL
============

# regfile

Architectural register file and the responder for the processor's regfile port group. It accepts one write per cycle from the MW stage and serves two combinational reads to the FD stage. Register r0 is hardwired to zero. Same-cycle write data is forwarded to the read ports, so the pipeline needs no negedge write and no extra W→D bypass.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH

Ports:
- clock  input  1  master clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears every register to 0
- ctrl_writeEnable  input  1  write strobe from the processor
- ctrl_writeReg  input  ADDR_WIDTH  destination register index
- data_writeReg  input  DATA_WIDTH  write data
- ctrl_readRegA  input  ADDR_WIDTH  port A source index
- ctrl_readRegB  input  ADDR_WIDTH  port B source index
- data_readRegA  output  DATA_WIDTH  port A read data
- data_readRegB  output  DATA_WIDTH  port B read data

Decided: one clock (`clock`); reset (`reset`) is asynchronous and active-high.

## Operation
- Storage: registers r1..r(NUM_REGS-1), each DATA_WIDTH wide. r0 has no storage and always reads as 0.
- Write: when ctrl_writeEnable=1 and ctrl_writeReg≠0, the register at ctrl_writeReg loads data_writeReg on the rising edge of clock.
  - A write to r0 is accepted and discarded; no register changes.
  - Only one register is written per edge, selected by a one-hot decode of ctrl_writeReg.
- Read: each port is combinational.
  - data_readRegX = 0 if ctrl_readRegX = 0.
  - Otherwise, data_readRegX = data_writeReg if ctrl_writeEnable=1 and ctrl_writeReg = ctrl_readRegX (write-through bypass).
  - Otherwise, data_readRegX = the stored value of r[ctrl_readRegX].
- Ports A and B are independent. Both may read the same index, including the one being written; each port applies the bypass rule on its own.
- Data is stored unmodified; there is no sign handling.
- Unknown inputs: X on ctrl_writeEnable must not corrupt registers in simulation. Gate the write with `ctrl_writeEnable === 1'b1` in behavioural checks only. RTL uses plain logic.

## Timing
- Reset: asserting reset clears all of r1..r31 to 0 immediately, independent of clock.
  - While reset is held, writes are ignored.
  - Read ports still return 0 for stored registers. The bypass path stays active, so a read whose index matches an enabled write returns data_writeReg even during reset. This is required behaviour.
- Write latency: a write lands at rising edge N. After edge N it is visible through storage. During cycle N−1 (the write cycle itself) it is visible through the bypass.
- Read latency: 0 cycles (combinational from the ctrl_readReg*, ctrl_writeReg, ctrl_writeEnable and data_writeReg inputs).
- Reset deasserted concurrently with an enabled write: the first rising edge after deassertion performs the write. Writes presented before deassertion are lost.
- Back-to-back writes to the same register: the last edge wins. A read in the second cycle returns the second data via the bypass.

## Structure
- Shared package `regfile_pkg`:
  - REG_ZERO = 5'd0
  - DATA_WIDTH / ADDR_WIDTH / NUM_REGS defaults
  - REG_STATUS = 5'd30, reserved for the overflow/exception status writes added to the processor later; the regfile treats it as an ordinary register.
- Sub-module `reg_cell`: one DATA_WIDTH register with async reset and load enable, in the same style as the existing PC register. Instantiate it NUM_REGS−1 times through a generate loop.
- Write decode (5→32 one-hot, bit 0 forced low) and the two read muxes with bypass live in the top module.

## Test plan
- Reset, then read all 32 indices on both ports → every read = 0x00000000.
- Write r5=0x12345678; next cycle read A=r5, B=r0 → A=0x12345678, B=0.
- Write r0=0xFFFFFFFF, then read r0 on both ports → 0. Write r1=0xFFFFFFFF in the same test; read r1 after → 0xFFFFFFFF; no other register changed.
- Same cycle: writeEnable=1, writeReg=7, data=0xDEADBEEF, readRegA=7, readRegB=7 → both ports = 0xDEADBEEF before the edge. After the edge, with writeEnable=0, both still read 0xDEADBEEF.
- Write r3=0xA, then r3=0xB on consecutive cycles, reading r3 each cycle → reads 0xA, then 0xB (bypass), then 0xB (stored).
- Load r1..r31 with distinct values, pulse reset mid-cycle (no clock edge) → all reads = 0 immediately. First write after deassertion to r9=0x55 → r9=0x55 and all other registers still 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the architectural register file
//
// Purpose: default geometry of the register file and the register indices that
//          have a fixed meaning to the rest of the processor.
// Ports:   none (package).
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int DEFAULT_NUM_REGS   = 32;

   typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;

   // r0 has no storage and always reads as zero.
   localparam reg_idx_t REG_ZERO   = 5'd0;
   // Destination of the overflow/exception status writes; stored like any other register.
   localparam reg_idx_t REG_STATUS = 5'd30;

endpackage

// File: rtl/regfile_reg_cell.sv
// rtl/regfile_reg_cell.sv - one data register with asynchronous reset and load enable
//
// Purpose: storage element for a single architectural register.
// Ports:   clock     - rising-edge clock
//          reset     - asynchronous, active-high; clears the register to 0
//          load_en   - load load_data on the next rising edge
//          load_data - value to load
//          value     - current stored value
module reg_cell
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] value_q;

   always_comb begin
      value_d = value_q;
      if (load_en) begin
         value_d = load_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - architectural register file, one write port, two bypassed read ports
//
// Purpose: holds r1..r(NUM_REGS-1); r0 reads as zero. Same-cycle write data is
//          forwarded to the read ports so the pipeline needs no extra W->D bypass.
// Ports:   clock, reset                  - rising-edge clock, async active-high reset
//          ctrl_writeEnable/writeReg     - write strobe and destination index
//          data_writeReg                 - write data
//          ctrl_readRegA/B               - read indices
//          data_readRegA/B               - combinational read data
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   // Bit 0 of the one-hot decode is omitted entirely: r0 can never be loaded.
   logic [NUM_REGS-1:1]   write_onehot;
   logic [DATA_WIDTH-1:0] reg_value [NUM_REGS];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      if (i == 0) begin : g_zero
         assign reg_value[i] = '0;
      end else begin : g_cell
         assign write_onehot[i] = ctrl_writeEnable & (ctrl_writeReg == ADDR_WIDTH'(i));

         reg_cell #(
            .WIDTH     (DATA_WIDTH)
         ) u_cell (
            .clock     (clock),
            .reset     (reset),
            .load_en   (write_onehot[i]),
            .load_data (data_writeReg),
            .value     (reg_value[i])
         );
      end
   end

   // Priority: r0 forces zero, then the write-through bypass, then storage.
   // The bypass is deliberately not gated by reset.
   always_comb begin
      data_readRegA = reg_value[ctrl_readRegA];
      if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
         data_readRegA = data_writeReg;
      end
      if (ctrl_readRegA == ZERO_IDX) begin
         data_readRegA = '0;
      end
   end

   always_comb begin
      data_readRegB = reg_value[ctrl_readRegB];
      if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
         data_readRegB = data_writeReg;
      end
      if (ctrl_readRegB == ZERO_IDX) begin
         data_readRegB = '0;
      end
   end

endmodule
